// File: rtl/register_file.sv
// Multi-register file: one synchronous write port, two combinational read ports,
// sequential clear sweep, optional hardwired zero register. Optional build macro: REGFILE_BYPASS_EN.
module register_file #(
  parameter  int WIDTH    = 8,
  parameter  int DEPTH    = 8,
  parameter  int ZERO_REG = 0,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [WIDTH-1:0]  rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  rdata_b,
  input  logic              clr_req,
  output logic              busy,
  output logic              wr_drop
);

  typedef enum logic {IDLE, SWEEP} state_t;

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(DEPTH - 1);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic               wr_drop_q, wr_drop_d;
  logic [WIDTH-1:0]   regs_q [DEPTH];
  logic [WIDTH-1:0]   regs_d [DEPTH];

  // An address is usable if it names a real register that is not hardwired to zero.
  function automatic logic usable(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < DEPTH_C) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    wr_drop_d = 1'b0;
    regs_d    = regs_q;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d   = SWEEP;
          idx_d     = '0;
          wr_drop_d = we;
        end else if (we && usable(waddr)) begin
          regs_d[waddr] = wdata;
        end
      end
      SWEEP: begin
        regs_d[idx_q] = '0;
        wr_drop_d     = we;
        if (idx_q == LAST_C) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + ADDR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      wr_drop_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      wr_drop_q <= wr_drop_d;
      regs_q    <= regs_d;
    end
  end

  logic [WIDTH-1:0] stored_a, stored_b;

  always_comb begin
    stored_a = usable(raddr_a) ? regs_q[raddr_a] : '0;
    stored_b = usable(raddr_b) ? regs_q[raddr_b] : '0;
  end

`ifdef REGFILE_BYPASS_EN
  // Forward the in-flight write to a matching read port in the same cycle.
  logic wr_live;
  assign wr_live = we && (state_q == IDLE) && !clr_req && usable(waddr);
  assign rdata_a = (wr_live && (waddr == raddr_a)) ? wdata : stored_a;
  assign rdata_b = (wr_live && (waddr == raddr_b)) ? wdata : stored_b;
`else
  assign rdata_a = stored_a;
  assign rdata_b = stored_b;
`endif

  assign busy    = (state_q == SWEEP);
  assign wr_drop = wr_drop_q;

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: an array-based model checked every cycle on two instances
// (8 deep / no zero reg, 6 deep / zero reg), plus directed literal expectations.
module tb_register_file;
  logic       clk = 1'b0;
  logic       reset;
  logic       we, clr_req;
  logic [2:0] waddr, raddr_a, raddr_b;
  logic [7:0] wdata;
  logic [1:0][7:0] ra, rb;
  logic [1:0] bz, dr;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  register_file #(.WIDTH(8), .DEPTH(8), .ZERO_REG(0)) u_rf0 (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .rdata_a(ra[0]), .raddr_b(raddr_b), .rdata_b(rb[0]),
    .clr_req(clr_req), .busy(bz[0]), .wr_drop(dr[0]));

  register_file #(.WIDTH(8), .DEPTH(6), .ZERO_REG(1)) u_rf1 (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .rdata_a(ra[1]), .raddr_b(raddr_b), .rdata_b(rb[1]),
    .clr_req(clr_req), .busy(bz[1]), .wr_drop(dr[1]));

  // Behavioural model: register contents plus "sweep in progress" and its position.
  int         dep [2] = '{8, 6};
  int         zr  [2] = '{0, 1};
  logic [7:0] m_mem [2][8];
  bit         m_sweep [2];
  int         m_pos [2];
  bit         m_drop [2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!reset) begin
        for (int i = 0; i < 8; i++) m_mem[k][i] = 8'h00;
        m_sweep[k] = 1'b0;
        m_pos[k]   = 0;
        m_drop[k]  = 1'b0;
      end else begin
        m_drop[k] = we && (m_sweep[k] || clr_req);
        if (m_sweep[k]) begin
          m_mem[k][m_pos[k]] = 8'h00;
          m_pos[k] = m_pos[k] + 1;
          if (m_pos[k] == dep[k]) m_sweep[k] = 1'b0;
        end else if (clr_req) begin
          m_sweep[k] = 1'b1;
          m_pos[k]   = 0;
        end else if (we && int'(waddr) < dep[k] && !(zr[k] != 0 && waddr == 3'd0)) begin
          m_mem[k][waddr] = wdata;
        end
      end
    end
    chk_en = 1'b1;
  end

  function automatic logic [7:0] exp_rd(int k, logic [2:0] a);
    if (int'(a) >= dep[k] || (zr[k] != 0 && a == 3'd0)) return 8'h00;
`ifdef REGFILE_BYPASS_EN
    if (we && !m_sweep[k] && !clr_req && a == waddr &&
        int'(waddr) < dep[k] && !(zr[k] != 0 && waddr == 3'd0)) return wdata;
`endif
    return m_mem[k][a];
  endfunction

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("model_rdata_a[%0d]", k), ra[k], exp_rd(k, raddr_a));
        chk($sformatf("model_rdata_b[%0d]", k), rb[k], exp_rd(k, raddr_b));
        chk($sformatf("model_busy[%0d]", k), {7'd0, bz[k]}, {7'd0, m_sweep[k]});
        chk($sformatf("model_wr_drop[%0d]", k), {7'd0, dr[k]}, {7'd0, m_drop[k]});
      end
    end
  end

  // Apply one cycle of inputs just after the rising edge, then wait for the sample point.
  task automatic drive(input logic w, input logic [2:0] wa, input logic [7:0] wd, input logic c);
    @(posedge clk); #1;
    we = w; waddr = wa; wdata = wd; clr_req = c;
    @(negedge clk);
  endtask

  int n0, n1;

  initial begin
    reset = 1'b0; we = 1'b0; clr_req = 1'b0;
    waddr = 3'd0; wdata = 8'h00; raddr_a = 3'd0; raddr_b = 3'd0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("reset_busy", {7'd0, bz[0]}, 8'h00);
    chk("reset_rd", ra[0], 8'h00);

    // Read-during-write on a freshly reset register.
    raddr_a = 3'd2;
    drive(1'b1, 3'd2, 8'hC3, 1'b0);
`ifdef REGFILE_BYPASS_EN
    chk("rdw_same_cycle", ra[0], 8'hC3);
`else
    chk("rdw_same_cycle", ra[0], 8'h00);
`endif
    drive(1'b0, 3'd0, 8'h00, 1'b0);
    chk("rdw_next_cycle", ra[0], 8'hC3);

    // Basic writes and reads.
    raddr_a = 3'd3; raddr_b = 3'd5;
    drive(1'b1, 3'd3, 8'hAA, 1'b0);
    drive(1'b1, 3'd5, 8'h55, 1'b0);
    chk("wr_a3", ra[0], 8'hAA);
    drive(1'b0, 3'd0, 8'h00, 1'b0);
    chk("wr_b5", rb[0], 8'h55);
    for (int i = 0; i < 8; i++) begin
      raddr_a = 3'(i);
      drive(1'b0, 3'd0, 8'h00, 1'b0);
    end
    chk("rd_unwritten", ra[0] | 8'h00, (raddr_a == 3'd7) ? 8'h00 : 8'hFF);

    // Fill then sweep.
    for (int i = 0; i < 8; i++) drive(1'b1, 3'(i), 8'h10 + 8'(i), 1'b0);
    raddr_a = 3'd7; raddr_b = 3'd7;
    drive(1'b0, 3'd0, 8'h00, 1'b0);
    chk("fill_7", ra[0], 8'h17);
    chk("oor_read_d6", rb[1], 8'h00);
    raddr_a = 3'd2; raddr_b = 3'd3;
    drive(1'b0, 3'd0, 8'h00, 1'b1);
    chk("clr_cycle_busy", {7'd0, bz[0]}, 8'h00);
    n0 = 0; n1 = 0;
    for (int i = 1; i <= 12; i++) begin
      drive(1'b0, 3'd0, 8'h00, 1'b0);
      if (bz[0]) n0++;
      if (bz[1]) n1++;
      if (i == 4) begin
        chk("sweep_c4_r2", ra[0], 8'h00);
        chk("sweep_c4_r3", rb[0], 8'h13);
      end
      if (i == 9) chk("sweep_done", {7'd0, bz[0]}, 8'h00);
    end
    chk("busy_len_d8", 8'(n0), 8'd8);
    chk("busy_len_d6", 8'(n1), 8'd6);
    chk("after_sweep", rb[0], 8'h00);

    // Write and second clear during a sweep.
    drive(1'b1, 3'd6, 8'h66, 1'b0);
    drive(1'b0, 3'd0, 8'h00, 1'b1);
    n0 = 0;
    for (int i = 1; i <= 12; i++) begin
      drive(i == 2, 3'd6, 8'hFF, i == 4);
      if (bz[0]) n0++;
      if (i == 3) chk("drop_pulse", {7'd0, dr[0]}, 8'h01);
      if (i == 4) chk("drop_one_cycle", {7'd0, dr[0]}, 8'h00);
    end
    chk("busy_not_extended", 8'(n0), 8'd8);
    raddr_a = 3'd6;
    drive(1'b0, 3'd0, 8'h00, 1'b0);
    chk("addr6_zero", ra[0], 8'h00);

    // Write and clear in the same idle cycle.
    drive(1'b1, 3'd1, 8'h21, 1'b0);
    raddr_a = 3'd1;
    drive(1'b1, 3'd1, 8'h77, 1'b1);
    chk("wr_clr_no_bypass", ra[0], 8'h21);
    drive(1'b0, 3'd0, 8'h00, 1'b0);
    chk("wr_clr_drop", {7'd0, dr[0]}, 8'h01);
    for (int i = 0; i < 10; i++) drive(1'b0, 3'd0, 8'h00, 1'b0);
    chk("wr_clr_addr1", ra[0], 8'h00);

    // Reset in the middle of a sweep.
    drive(1'b1, 3'd5, 8'h5A, 1'b0);
    raddr_a = 3'd5;
    drive(1'b0, 3'd0, 8'h00, 1'b1);
    for (int i = 1; i <= 5; i++) drive(1'b0, 3'd0, 8'h00, 1'b0);
    chk("pre_reset_r5", ra[0], 8'h5A);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("midsweep_reset_busy", {7'd0, bz[0]}, 8'h00);
    chk("midsweep_reset_r5", ra[0], 8'h00);

    // Hardwired zero register and out-of-range write on the 6-deep instance.
    raddr_a = 3'd0; raddr_b = 3'd7;
    drive(1'b1, 3'd0, 8'h99, 1'b0);
    drive(1'b1, 3'd7, 8'h3C, 1'b0);
    chk("zr_read0", ra[1], 8'h00);
    chk("zr_no_drop", {7'd0, dr[1]}, 8'h00);
    chk("nozr_read0", ra[0], 8'h99);
    drive(1'b0, 3'd0, 8'h00, 1'b0);
    chk("oor_write_d6", rb[1], 8'h00);
    chk("oor_no_drop", {7'd0, dr[1]}, 8'h00);
    chk("d8_addr7", rb[0], 8'h3C);

    drive(1'b0, 3'd0, 8'h00, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
